// File: rtl/matrix_pkg.sv
// Shared definitions for the 3x3 matrix result path: sizes, FSM encoding and
// the helper that pulls one result word out of the packed result bus.
package matrix_pkg;

   localparam int unsigned W        = 8;
   localparam int unsigned NWORDS   = 9;
   localparam int unsigned IDXW     = 4;
   localparam int unsigned FLATW    = W * NWORDS;
   localparam int unsigned LAST_IDX = NWORDS - 1;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } state_e;

   // Word i of the packed results occupies bits [W*i+W-1 : W*i].
   function automatic logic [W-1:0] word_at(input logic [FLATW-1:0] flat,
                                            input int unsigned       i);
      return flat[i*W +: W];
   endfunction

endpackage

// File: rtl/matrix_result_reader_if.sv
// Word stream from the result reader to the display/UART path.
//   out_valid : word valid          out_ready : sink accepts the word
//   out_data  : result word         out_idx   : row*3+col of out_data
//   out_last  : high with the final (index 8) beat
interface matrix_result_reader_if;
   import matrix_pkg::*;

   logic            out_valid;
   logic            out_ready;
   logic [W-1:0]    out_data;
   logic [IDXW-1:0] out_idx;
   logic            out_last;

   modport master (output out_valid, output out_data, output out_idx,
                   output out_last, input out_ready);
   modport slave  (input out_valid, input out_data, input out_idx,
                   input out_last, output out_ready);
endinterface

// File: rtl/matrix_edge_det.sv
// Rising-edge detector with a registered history bit.
//   clk, reset : clock and synchronous active-high reset
//   sig_i      : level to watch
//   rise_c     : combinational, high while sig_i is high and was low last cycle
// A level already high in the first cycle after reset reads as a rise.
module matrix_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic sig_i,
   output logic rise_c
);

   logic sig_q;

   // History of the watched level.
   always_ff @(posedge clk) begin
      if (reset) sig_q <= 1'b0;
      else       sig_q <= sig_i;
   end

   assign rise_c = sig_i & ~sig_q;

endmodule

// File: rtl/matrix_result_reader.sv
// Snapshots the nine multiplier results on the rising edge of done and
// streams them row-major over a valid/ready interface, one word per beat.
//   clk, reset   : clock, synchronous active-high reset
//   done_i       : multiplier done level
//   res_flat_i   : packed results, M1 in [7:0] ... M9 in [71:64]
//   out_if       : word stream (valid/ready/data/idx/last)
//   busy_o       : capture until last beat accepted
//   frame_done_o : one-cycle pulse after the last beat is accepted
//   checksum_o   : sum of the frame's words mod 256, updated with frame_done
//   overrun_o    : sticky, done rose while a frame was still streaming
module matrix_result_reader
   import matrix_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   done_i,
   input  logic [FLATW-1:0]       res_flat_i,
   matrix_result_reader_if.master out_if,
   output logic                   busy_o,
   output logic                   frame_done_o,
   output logic [W-1:0]           checksum_o,
   output logic                   overrun_o
);

   state_e          state_q;
   logic [W-1:0]    buf_q [NWORDS];
   logic [W-1:0]    sum_q;
   logic            valid_q;
   logic [W-1:0]    data_q;
   logic [IDXW-1:0] idx_q;
   logic            last_q;
   logic            busy_q;
   logic            frame_done_q;
   logic [W-1:0]    checksum_q;
   logic            overrun_q;

   logic            done_rise_c;
   logic            accept_c;
   logic [W-1:0]    sum_nxt_c;
   logic [IDXW-1:0] idx_nxt_c;

   matrix_edge_det u_done_edge (
      .clk    (clk),
      .reset  (reset),
      .sig_i  (done_i),
      .rise_c (done_rise_c)
   );

   assign accept_c  = valid_q & out_if.out_ready;
   assign sum_nxt_c = sum_q + data_q;
   assign idx_nxt_c = idx_q + IDXW'(1);

   // Capture, stream and checksum FSM.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         for (int unsigned i = 0; i < NWORDS; i++) buf_q[i] <= '0;
         sum_q        <= '0;
         valid_q      <= 1'b0;
         data_q       <= '0;
         idx_q        <= '0;
         last_q       <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         checksum_q   <= '0;
         overrun_q    <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;

         // A new result while streaming (including the final accept cycle)
         // is dropped; only the flag records it.
         if (done_rise_c && state_q == STREAM) overrun_q <= 1'b1;

         case (state_q)
            IDLE: begin
               if (done_rise_c) begin
                  for (int unsigned i = 0; i < NWORDS; i++)
                     buf_q[i] <= word_at(res_flat_i, i);
                  sum_q   <= '0;
                  valid_q <= 1'b1;
                  idx_q   <= '0;
                  data_q  <= word_at(res_flat_i, 0);
                  last_q  <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= STREAM;
               end
            end
            STREAM: begin
               if (accept_c) begin
                  sum_q <= sum_nxt_c;
                  if (idx_q != IDXW'(LAST_IDX)) begin
                     idx_q  <= idx_nxt_c;
                     data_q <= buf_q[idx_nxt_c];
                     last_q <= (idx_nxt_c == IDXW'(LAST_IDX));
                  end else begin
                     valid_q      <= 1'b0;
                     last_q       <= 1'b0;
                     busy_q       <= 1'b0;
                     frame_done_q <= 1'b1;
                     checksum_q   <= sum_nxt_c;
                     state_q      <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign out_if.out_valid = valid_q;
   assign out_if.out_data  = data_q;
   assign out_if.out_idx   = idx_q;
   assign out_if.out_last  = last_q;
   assign busy_o           = busy_q;
   assign frame_done_o     = frame_done_q;
   assign checksum_o       = checksum_q;
   assign overrun_o        = overrun_q;

endmodule
